serial_subtractor: RTL and testbench

- Bit-serial unsigned subtractor; the inverse-operation counterpart of the team's parallel full adder.
- Accepts two WIDTH-bit operands over a valid/ready handshake and computes a - b one bit per cycle, LSB first.
- Returns a (WIDTH+1)-bit two's-complement difference over a second valid/ready handshake.
- Sits beside the adder in the arithmetic test datapath, so add/sub round-trips can be checked formally.

---
 rtl/serial_sub_pkg.sv | 12 +
 rtl/bit_subtractor.sv | 13 +
 rtl/serial_subtractor.sv | 109 ++++++++++
 tb/tb_serial_subtractor.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// rtl/serial_sub_pkg.sv - shared types and defaults for the bit-serial subtractor
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sub_state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/bit_subtractor.sv
// rtl/bit_subtractor.sv - combinational one-bit full subtractor (x - y - bin)
module bit_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial unsigned a - b, LSB first, with valid/ready in and out
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   diff,
    output logic             busy
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    sub_state_t       state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic             borrow_q, borrow_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-2:0] res_q, res_d;
    logic [WIDTH:0]   diff_q, diff_d;

    logic             bit_d;
    logic             bit_bout;
    logic [WIDTH-1:0] res_next;

    bit_subtractor u_bit_sub (
        .x    (a_sh_q[0]),
        .y    (b_sh_q[0]),
        .bin  (borrow_q),
        .d    (bit_d),
        .bout (bit_bout)
    );

    // Only WIDTH-1 bits are kept between cycles; the final bit completes the word on the last edge.
    assign res_next = {bit_d, res_q};

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        borrow_d = borrow_q;
        cnt_d    = cnt_q;
        res_d    = res_q;
        diff_d   = diff_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_sh_d   = a;
                    b_sh_d   = b;
                    borrow_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                borrow_d = bit_bout;
                res_d    = res_next[WIDTH-1:1];
                if (cnt_q == CNT_LAST) begin
                    diff_d  = {bit_bout, res_next};
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
            res_q    <= '0;
            diff_q   <= '0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            borrow_q <= borrow_d;
            cnt_q    <= cnt_d;
            res_q    <= res_d;
            diff_q   <= diff_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q == RUN);
    assign out_valid = (state_q == DONE);
    assign diff      = diff_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - table-driven and sequence checks for serial_subtractor
module tb_serial_subtractor;

    localparam int WIDTH = 8;
    localparam int MAX_WAIT = 40;
    // RUN (WIDTH edges) + one DONE edge + one IDLE edge between accepts
    localparam int ACC_SPACING = WIDTH + 2;

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   diff;
    logic             busy;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [WIDTH-1:0] va;
        logic [WIDTH-1:0] vb;
        logic [WIDTH:0]   exp;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic start_op(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb);
        int n;
        n = 0;
        while (!in_ready && n < MAX_WAIT) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_before_start", in_ready, 1'b1);
        a = va;
        b = vb;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < MAX_WAIT) begin
            @(negedge clk);
            lat++;
        end
    endtask

    vec_t vecs[7];
    int   lat;
    int   lat2;
    int   acc_cyc;
    int   prev_acc;
    logic seen;
    logic [WIDTH:0] expd;

    initial begin
        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        a = '0;
        b = '0;

        vecs[0] = '{8'h05, 8'h03, 9'h002};
        vecs[1] = '{8'h02, 8'h03, 9'h1FF};
        vecs[2] = '{8'h00, 8'hFF, 9'h101};
        vecs[3] = '{8'hFF, 8'h00, 9'h0FF};
        vecs[4] = '{8'h80, 8'h80, 9'h000};
        vecs[5] = '{8'h01, 8'h00, 9'h001};
        vecs[6] = '{8'h00, 8'h01, 9'h1FF};

        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_diff", diff, 9'h000);
        chk("rst_busy", busy, 1'b0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            start_op(vecs[i].va, vecs[i].vb);
            chk("busy_in_run", busy, 1'b1);
            wait_out(lat);
            chk("latency", lat, WIDTH);
            chk("diff_vec", diff, vecs[i].exp);
            @(negedge clk);
            chk("idle_after_xfer", in_ready, 1'b1);
            chk("ov_low_after_xfer", out_valid, 1'b0);
        end

        // back-pressure
        out_ready = 1'b0;
        start_op(8'hA0, 8'h0A);
        wait_out(lat);
        chk("bp_latency", lat, WIDTH);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (!out_valid || diff !== 9'h096 || in_ready || busy) seen = 1'b1;
            @(negedge clk);
        end
        chk("bp_hold_stable", seen, 1'b0);
        chk("bp_diff", diff, 9'h096);
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_single_xfer_ov", out_valid, 1'b0);
        chk("bp_single_xfer_rdy", in_ready, 1'b1);
        chk("bp_diff_kept", diff, 9'h096);

        // in_valid during RUN is ignored
        start_op(8'h10, 8'h01);
        repeat (2) @(negedge clk);
        a = 8'hFF;
        b = 8'hFF;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        wait_out(lat2);
        chk("ign_latency", 3 + lat2, WIDTH);
        chk("ign_diff", diff, 9'h00F);
        @(negedge clk);
        chk("ign_idle", in_ready, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (out_valid || busy) seen = 1'b1;
            @(negedge clk);
        end
        chk("ign_no_queued_op", seen, 1'b0);

        // reset mid-RUN
        start_op(8'h55, 8'h11);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_diff", diff, 9'h000);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_in_ready", in_ready, 1'b1);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("midrst_ready_after", in_ready, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid || busy) seen = 1'b1;
        end
        chk("midrst_no_result", seen, 1'b0);

        // back-to-back with in_valid held high
        out_ready = 1'b1;
        in_valid = 1'b1;
        prev_acc = 0;
        for (int i = 0; i < 20; i++) begin
            lat = 0;
            while (!in_ready && lat < MAX_WAIT) begin
                @(negedge clk);
                lat++;
            end
            chk("b2b_ready", in_ready, 1'b1);
            a = WIDTH'($urandom);
            b = WIDTH'($urandom);
            expd = ({1'b0, a} - {1'b0, b});
            acc_cyc = cyc + 1;
            @(negedge clk);
            wait_out(lat);
            chk("b2b_latency", lat, WIDTH);
            chk("b2b_diff", diff, expd);
            chk("b2b_borrow", diff[WIDTH], (a < b));
            if (i > 0) chk("b2b_spacing", acc_cyc - prev_acc, ACC_SPACING);
            prev_acc = acc_cyc;
            @(negedge clk);
        end
        in_valid = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
